fifo_rd_arbiter: RTL and testbench

Read-side arbiter for the asynchronous FIFO. It sits in the rdclk domain beside the read pointer and shares the single FIFO read port among NREQ consumers. Access is granted in round-robin order as whole bursts. The block drives rd_en, qualifies it against empty, and steers each read word to the granted consumer with a one-hot valid.

---
 rtl/fifo_rd_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter for the async FIFO read port (rdclk domain).
// Define RD_ARB_STALL_ABORT_EN to abort bursts stalled on empty for STALL_LIMIT cycles.
module fifo_rd_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_MAX   = 16,
  parameter int unsigned STALL_LIMIT = 32
) (
  input  logic                                   rdclk,
  input  logic                                   rd_rst_n,
  input  logic [NREQ-1:0]                        req,
  input  logic [NREQ*($clog2(BURST_MAX)+1)-1:0]  req_len,
  input  logic                                   empty,
  input  logic [DATA_WIDTH-1:0]                  rdata,
  output logic                                   rd_en,
  output logic [NREQ-1:0]                        gnt,
  output logic [DATA_WIDTH-1:0]                  dout,
  output logic [NREQ-1:0]                        dout_valid,
  output logic [NREQ-1:0]                        burst_done,
  output logic                                   aborted,
  output logic                                   busy
);

  localparam int unsigned LEN_W = $clog2(BURST_MAX) + 1;
  localparam int unsigned IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_e;

  state_e            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   dout_valid_q;
  logic [NREQ-1:0]   burst_done_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [IDX_W-1:0]  gnt_idx_q;
  logic [IDX_W-1:0]  last_gnt_q;

  logic [IDX_W-1:0]  gnt_idx_d;
  logic [IDX_W-1:0]  cand_c;
  logic              found_c;
  logic [NREQ-1:0]   gnt_d;
  logic [LEN_W-1:0]  raw_len_c;
  logic [LEN_W-1:0]  len_d;
  logic              stall_hit_c;

`ifdef RD_ARB_STALL_ABORT_EN
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  logic [STALL_W-1:0] stall_q;
  logic               aborted_q;
  assign stall_hit_c = (stall_q == STALL_W'(STALL_LIMIT));
  assign aborted     = aborted_q;
`else
  assign stall_hit_c = 1'b0;
  assign aborted     = 1'b0;
`endif

  // Round-robin pick: first requester above the last grant, wrapping.
  always_comb begin
    found_c   = 1'b0;
    gnt_idx_d = last_gnt_q;
    cand_c    = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand_c = IDX_W'((32'(last_gnt_q) + 32'(k)) % NREQ);
      if (!found_c && req[cand_c]) begin
        found_c   = 1'b1;
        gnt_idx_d = cand_c;
      end
    end
    gnt_d            = '0;
    gnt_d[gnt_idx_d] = 1'b1;
  end

  // Clamp the requested length into 1..BURST_MAX.
  always_comb begin
    raw_len_c = req_len[gnt_idx_d*LEN_W +: LEN_W];
    len_d     = raw_len_c;
    if (raw_len_c == '0)
      len_d = LEN_W'(1);
    else if (raw_len_c > LEN_W'(BURST_MAX))
      len_d = LEN_W'(BURST_MAX);
  end

  assign rd_en      = (state_q == S_BURST) && !empty && (remaining_q != '0) && !stall_hit_c;
  assign gnt        = gnt_q;
  assign dout_valid = dout_valid_q;
  assign burst_done = burst_done_q;
  assign busy       = (state_q != S_IDLE);
  assign dout       = (|dout_valid_q) ? rdata : '0;

  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      last_gnt_q   <= IDX_W'(NREQ - 1);
      remaining_q  <= '0;
      dout_valid_q <= '0;
      burst_done_q <= '0;
`ifdef RD_ARB_STALL_ABORT_EN
      stall_q      <= '0;
      aborted_q    <= 1'b0;
`endif
    end else begin
      dout_valid_q <= gnt_q & {NREQ{rd_en}};
      burst_done_q <= '0;
`ifdef RD_ARB_STALL_ABORT_EN
      aborted_q    <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            remaining_q <= len_d;
            state_q     <= S_BURST;
`ifdef RD_ARB_STALL_ABORT_EN
            stall_q     <= '0;
`endif
          end
        end
        S_BURST: begin
          if (stall_hit_c) begin
            remaining_q  <= '0;
            burst_done_q <= gnt_q;
            state_q      <= S_FLUSH;
`ifdef RD_ARB_STALL_ABORT_EN
            aborted_q    <= 1'b1;
`endif
          end else if (rd_en) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              burst_done_q <= gnt_q;
              state_q      <= S_FLUSH;
            end
`ifdef RD_ARB_STALL_ABORT_EN
            stall_q <= '0;
          end else if (empty) begin
            stall_q <= stall_q + STALL_W'(1);
`endif
          end
        end
        S_FLUSH: begin
          gnt_q      <= '0;
          last_gnt_q <= gnt_idx_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed self-checking bench for fifo_rd_arbiter (NREQ=4, BURST_MAX=16).
module tb_fifo_rd_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned LEN_W = 5;

  logic                    rdclk = 1'b0;
  logic                    rd_rst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ*LEN_W-1:0]   req_len;
  logic                    empty;
  logic [DW-1:0]           rdata;
  logic                    rd_en;
  logic [NREQ-1:0]         gnt;
  logic [DW-1:0]           dout;
  logic [NREQ-1:0]         dout_valid;
  logic [NREQ-1:0]         burst_done;
  logic                    aborted;
  logic                    busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fifo_rd_arbiter #(.NREQ(4), .DATA_WIDTH(8), .BURST_MAX(16), .STALL_LIMIT(32)) dut (
    .rdclk(rdclk), .rd_rst_n(rd_rst_n), .req(req), .req_len(req_len),
    .empty(empty), .rdata(rdata), .rd_en(rd_en), .gnt(gnt), .dout(dout),
    .dout_valid(dout_valid), .burst_done(burst_done), .aborted(aborted), .busy(busy)
  );

  always #5 rdclk = ~rdclk;

  function automatic logic [14:0] pk(logic [3:0] g, logic r, logic [3:0] dv,
                                     logic [3:0] bd, logic b, logic a);
    return {g, r, dv, bd, b, a};
  endfunction

  task automatic step();
    @(posedge rdclk);
    #1;
    cyc++;
    rdata = 8'((cyc * 13 + 5) % 256);
  endtask

  task automatic set_len(input int idx, input int len);
    req_len[idx*LEN_W +: LEN_W] = 5'(len);
  endtask

  task automatic apply_reset();
    rd_rst_n = 1'b0; req = '0; empty = 1'b0; req_len = '0;
    step(); step();
    rd_rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    rd_rst_n = 1'b0; req = 4'b1111; req_len = '1; empty = 1'b0;
    step(); #1;
    obs = pk(gnt, rd_en, dout_valid, burst_done, busy, aborted);
    checks++;
    if (obs !== 15'd0) begin failures++; $display("FAIL reset_outputs: got %b want 0", obs); end
    checks++;
    if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h want 00", dout); end
    req = '0; req_len = '0;
    rd_rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_burst();
    logic [14:0] obs, exp_v;
    logic [3:0]  edv;
    req = 4'b0001; set_len(0, 3); empty = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) req = '0;
      #1;
      edv   = (i >= 2 && i <= 4) ? 4'b0001 : 4'b0000;
      exp_v = pk((i <= 4) ? 4'b0001 : 4'b0000, i <= 3, edv,
                 (i == 4) ? 4'b0001 : 4'b0000, i <= 4, 1'b0);
      obs   = pk(gnt, rd_en, dout_valid, burst_done, busy, aborted);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL single_burst c%0d: got %b want %b", i, obs, exp_v); end
      checks++;
      if (dout !== ((|edv) ? rdata : 8'h00)) begin
        failures++; $display("FAIL single_dout c%0d: got %h want %h", i, dout, (|edv) ? rdata : 8'h00);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [14:0] obs, exp_v;
    logic [3:0]  eg;
    int ph, b;
    apply_reset();
    set_len(0, 2); set_len(2, 2); req = 4'b0101;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) req = '0;
      #1;
      ph    = (i - 1) % 4;
      b     = (i - 1) / 4;
      eg    = (ph < 3) ? ((b % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
      exp_v = pk(eg, ph < 2, (ph == 1 || ph == 2) ? eg : 4'b0000,
                 (ph == 2) ? eg : 4'b0000, ph < 3, 1'b0);
      obs   = pk(gnt, rd_en, dout_valid, burst_done, busy, aborted);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL round_robin c%0d: got %b want %b", i, obs, exp_v); end
    end
  endtask

  task automatic test_empty_stall();
    logic [14:0] obs, exp_v;
    int dvc = 0;
    req = 4'b0010; set_len(1, 4); empty = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 1) req = '0;
      empty = (i >= 3 && i <= 7);
      #1;
      exp_v = pk((i <= 10) ? 4'b0010 : 4'b0000, (i == 1 || i == 2 || i == 8 || i == 9),
                 (i == 2 || i == 3 || i == 9 || i == 10) ? 4'b0010 : 4'b0000,
                 (i == 10) ? 4'b0010 : 4'b0000, i <= 10, 1'b0);
      obs   = pk(gnt, rd_en, dout_valid, burst_done, busy, aborted);
      if (|dout_valid) dvc++;
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL empty_stall c%0d: got %b want %b", i, obs, exp_v); end
    end
    empty = 1'b0;
    checks++;
    if (dvc !== 4) begin failures++; $display("FAIL empty_stall_count: got %0d want 4", dvc); end
  endtask

  task automatic run_burst(input logic [3:0] r, output logic [3:0] g,
                           output int reads, output int dvs, output int bcyc);
    reads = 0; dvs = 0; bcyc = 0; g = '0;
    req = r; empty = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) req = '0;
      #1;
      if (k == 1) g = gnt;
      if (rd_en) reads++;
      if (|dout_valid) dvs++;
      if (busy) bcyc++;
      if (!busy) break;
    end
  endtask

  task automatic test_length_clamp();
    logic [3:0] g;
    int reads, dvs, bcyc;
    set_len(3, 0);
    run_burst(4'b1000, g, reads, dvs, bcyc);
    checks++;
    if (g !== 4'b1000) begin failures++; $display("FAIL clamp0_gnt: got %b want 1000", g); end
    checks++;
    if (reads !== 1 || dvs !== 1 || bcyc !== 2) begin
      failures++; $display("FAIL clamp0: got reads=%0d dv=%0d busy=%0d want 1 1 2", reads, dvs, bcyc);
    end
    set_len(0, 31);
    run_burst(4'b0001, g, reads, dvs, bcyc);
    checks++;
    if (g !== 4'b0001) begin failures++; $display("FAIL clamp31_gnt: got %b want 0001", g); end
    checks++;
    if (reads !== 16 || dvs !== 16 || bcyc !== 17) begin
      failures++; $display("FAIL clamp31: got reads=%0d dv=%0d busy=%0d want 16 16 17", reads, dvs, bcyc);
    end
  endtask

  task automatic test_stall();
    int dvc = 0, rd_stall = 0, ab_cyc = -1, done_cyc = -1;
    logic [3:0] ab_bd = '0;
    logic busy48 = 1'b0;
    apply_reset();
    set_len(0, 8); req = 4'b0001; empty = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 1) req = '0;
      empty = (i >= 4 && i <= 48);
      #1;
      if (|dout_valid) dvc++;
      if (rd_en && i >= 4 && i <= 48) rd_stall++;
      if (aborted && ab_cyc < 0) begin ab_cyc = i; ab_bd = burst_done; end
      if ((|burst_done) && done_cyc < 0) done_cyc = i;
      if (i == 48) busy48 = busy;
    end
    empty = 1'b0;
    checks++;
    if (rd_stall !== 0) begin failures++; $display("FAIL stall_rd_en: got %0d reads while empty want 0", rd_stall); end
`ifdef RD_ARB_STALL_ABORT_EN
    checks++;
    if (!(ab_cyc >= 36 && ab_cyc <= 38) || ab_bd !== 4'b0001) begin
      failures++; $display("FAIL stall_abort: got cyc=%0d bd=%b want 36..38 0001", ab_cyc, ab_bd);
    end
    checks++;
    if (dvc !== 3 || done_cyc !== ab_cyc) begin
      failures++; $display("FAIL stall_abort_data: got dv=%0d done=%0d want 3 %0d", dvc, done_cyc, ab_cyc);
    end
`else
    checks++;
    if (ab_cyc !== -1 || busy48 !== 1'b1) begin
      failures++; $display("FAIL stall_wait: got abort_cyc=%0d busy48=%b want -1 1", ab_cyc, busy48);
    end
    checks++;
    if (dvc !== 8 || done_cyc !== 54) begin
      failures++; $display("FAIL stall_resume: got dv=%0d done=%0d want 8 54", dvc, done_cyc);
    end
`endif
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL stall_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    logic [14:0] obs;
    int spurious = 0;
    req = 4'b0100; set_len(2, 6); empty = 1'b0;
    step(); req = '0;
    step(); #1;
    checks++;
    if (gnt !== 4'b0100 || rd_en !== 1'b1) begin
      failures++; $display("FAIL midrst_pre: got gnt=%b rd_en=%b want 0100 1", gnt, rd_en);
    end
    step();
    rd_rst_n = 1'b0;
    #1;
    obs = pk(gnt, rd_en, dout_valid, burst_done, busy, aborted);
    checks++;
    if (obs !== 15'd0 || dout !== 8'h00) begin
      failures++; $display("FAIL midrst_clear: got %b dout=%h want 0 00", obs, dout);
    end
    step(); step();
    rd_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if ((|burst_done) || (|dout_valid) || busy) spurious++;
    end
    checks++;
    if (spurious !== 0) begin failures++; $display("FAIL midrst_quiet: got %0d active cycles want 0", spurious); end
    set_len(0, 1); set_len(1, 1); set_len(2, 1); set_len(3, 1);
    req = 4'b1111;
    step(); req = '0; #1;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_next_gnt: got %b want 0001", gnt); end
    step(); step(); step();
  endtask

  initial begin
    rd_rst_n = 1'b0; req = '0; req_len = '0; empty = 1'b0; rdata = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_empty_stall();
    test_length_clamp();
    test_stall();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
